// File: rtl/cic_pkg.sv
// Shared CIC helpers: width-growth arithmetic and trim/extend macros for the
// width rules used by both the decimator and the interpolator.
`ifndef CIC_PKG_MACROS_SVH
`define CIC_PKG_MACROS_SVH
// Keep the OW most significant bits of a VW-bit vector (drops LSBs).
`define CIC_TRIM(v, vw, ow) v[(vw)-1 -: (ow)]
// Left-justify a VW-bit vector into OW bits, OW > VW (zero-fills LSBs).
`define CIC_EXTEND(v, vw, ow) {v, {((ow)-(vw)){1'b0}}}
`endif

package cic_pkg;

  typedef enum logic {
    CIC_DECIMATE    = 1'b0,
    CIC_INTERPOLATE = 1'b1
  } cic_dir_e;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < v) r = 32'(i) + 32'd1;
    end
    return r;
  endfunction

  // Bits of growth: (R*M)^N for the decimator, (R*M)^N / R for the interpolator.
  function automatic int unsigned cic_growth(input int unsigned n, input int unsigned r,
                                             input int unsigned m, input cic_dir_e dir);
    longint unsigned g;
    g = 64'd1;
    for (int unsigned k = 0; k < n; k++) g = g * (64'(r) * 64'(m));
    if (dir == CIC_INTERPOLATE) g = g / 64'(r);
    return clog2(g);
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// W-bit enabled accumulator with synchronous clear.
// Ports: clk, i_clr (sync clear), i_en (accumulate enable), i_in (addend),
//        o_acc (registered running sum, modular wrap).
module cic_integrator
  import cic_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_in,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (i_clr)     r_acc <= '0;
    else if (i_en) r_acc <= r_acc + i_in;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cic_interpolator.sv
// Cascaded integrator-comb interpolator: comb at the low rate, zero-stuff by R,
// integrators at the high rate. One x consumed per R enabled clocks.
// Ports: clk, rst (sync, active-high), enabled (clock enable), x (low-rate in),
//        clk_transfer (comb strobe, cycle that consumes x), y (registered
//        high-rate out), y_valid (registered, high for each enabled cycle).
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned R         = 4,
  parameter int unsigned M         = 1,
  parameter int unsigned X_WIDTH   = 8,
  parameter int unsigned Y_WIDTH   = 8,
  parameter int unsigned PRECISION = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enabled,
  input  logic [X_WIDTH-1:0] x,
  output logic               clk_transfer,
  output logic [Y_WIDTH-1:0] y,
  output logic               y_valid
);

  localparam int unsigned GROWTH = cic_growth(N, R, M, CIC_INTERPOLATE);
  localparam int unsigned W      = PRECISION + GROWTH;
  localparam int unsigned PW     = (R > 1) ? clog2(64'(R)) : 1;

  logic [PW-1:0]        r_phase;
  logic [PRECISION-1:0] w_xp;
  logic [W-1:0]         w_c0;
  logic [W-1:0]         w_stuff;
  logic [W-1:0]         w_int_out;
  logic [Y_WIDTH-1:0]   w_y_next;
  logic [Y_WIDTH-1:0]   r_y;
  logic                 r_y_valid;

  // Phase counter; reset forces the first post-reset enabled cycle to transfer.
  always_ff @(posedge clk) begin
    if (rst)          r_phase <= '0;
    else if (enabled) r_phase <= (r_phase == PW'(R - 1)) ? '0 : r_phase + PW'(1);
  end

  assign clk_transfer = enabled & ~rst & (r_phase == '0);

  // Input conditioning to PRECISION bits, then sign extension to W.
  if (PRECISION < X_WIDTH) begin : g_x_trim
    logic w_unused_x_lsbs;
    assign w_xp            = `CIC_TRIM(x, X_WIDTH, PRECISION);
    assign w_unused_x_lsbs = ^x[X_WIDTH-PRECISION-1:0];
  end else if (PRECISION == X_WIDTH) begin : g_x_pass
    assign w_xp = x;
  end else begin : g_x_ext
    assign w_xp = `CIC_EXTEND(x, X_WIDTH, PRECISION);
  end

  assign w_c0 = W'($signed(w_xp));

  // Comb chain at the low rate; delay lines advance only on transfer cycles.
  for (genvar k = 0; k < N; k++) begin : g_comb
    logic [W-1:0] w_in;
    logic [W-1:0] w_out;
    logic [W-1:0] r_dly [M];

    if (k == 0) begin : g_first
      assign w_in = w_c0;
    end else begin : g_next
      assign w_in = g_comb[k-1].w_out;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int m = 0; m < M; m++) r_dly[m] <= '0;
      end else if (clk_transfer) begin
        r_dly[0] <= w_in;
        for (int m = 1; m < M; m++) r_dly[m] <= r_dly[m-1];
      end
    end

    assign w_out = w_in - r_dly[M-1];
  end

  // Zero-stuff: comb output enters the integrators only on transfer cycles.
  assign w_stuff = clk_transfer ? g_comb[N-1].w_out : '0;

  // Integrator pipeline: each stage adds the previous stage's registered sum.
  for (genvar k = 0; k < N; k++) begin : g_int
    logic [W-1:0] w_in;
    logic [W-1:0] w_acc;

    if (k == 0) begin : g_first
      assign w_in = w_stuff;
    end else begin : g_next
      assign w_in = g_int[k-1].w_acc;
    end

    cic_integrator #(.W(W)) u_int (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (enabled),
      .i_in  (w_in),
      .o_acc (w_acc)
    );
  end

  assign w_int_out = g_int[N-1].w_acc;

  // Output width rule: keep MSBs when narrowing, left-justify when widening.
  if (Y_WIDTH <= W) begin : g_y_trim
    assign w_y_next = `CIC_TRIM(w_int_out, W, Y_WIDTH);
    if (Y_WIDTH < W) begin : g_lsbs
      logic w_unused_y_lsbs;
      assign w_unused_y_lsbs = ^w_int_out[W-Y_WIDTH-1:0];
    end
  end else begin : g_y_ext
    assign w_y_next = `CIC_EXTEND(w_int_out, W, Y_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= enabled;
      if (enabled) r_y <= w_y_next;
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator: four instances with different
// parameter sets share clk/rst/enabled; each test drives and checks one.
module tb_cic_interpolator;

  // Instance ids
  localparam int ZOH  = 0;  // N=1 R=4
  localparam int RAMP = 1;  // N=2 R=4
  localparam int WID  = 2;  // PRECISION=3 N=1 R=2
  localparam int DEF  = 3;  // defaults N=3 R=4 M=1

  // Default-instance constants for the convolution model: W = 8 + log2(64/4)
  localparam int N_D = 3;
  localparam int R_D = 4;
  localparam int M_D = 1;
  localparam int W_D = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] x_d  [4];
  logic [7:0] y_d  [4];
  logic       ct_d [4];
  logic       yv_d [4];

  always #5 clk = ~clk;

  cic_interpolator #(.N(1), .R(4), .M(1), .X_WIDTH(8), .Y_WIDTH(8), .PRECISION(8)) u_zoh (
    .clk(clk), .rst(rst), .enabled(en), .x(x_d[ZOH]),
    .clk_transfer(ct_d[ZOH]), .y(y_d[ZOH]), .y_valid(yv_d[ZOH]));

  cic_interpolator #(.N(2), .R(4), .M(1), .X_WIDTH(8), .Y_WIDTH(8), .PRECISION(8)) u_ramp (
    .clk(clk), .rst(rst), .enabled(en), .x(x_d[RAMP]),
    .clk_transfer(ct_d[RAMP]), .y(y_d[RAMP]), .y_valid(yv_d[RAMP]));

  cic_interpolator #(.N(1), .R(2), .M(1), .X_WIDTH(8), .Y_WIDTH(8), .PRECISION(3)) u_wid (
    .clk(clk), .rst(rst), .enabled(en), .x(x_d[WID]),
    .clk_transfer(ct_d[WID]), .y(y_d[WID]), .y_valid(yv_d[WID]));

  cic_interpolator #(.N(N_D), .R(R_D), .M(M_D), .X_WIDTH(8), .Y_WIDTH(8), .PRECISION(8)) u_def (
    .clk(clk), .rst(rst), .enabled(en), .x(x_d[DEF]),
    .clk_transfer(ct_d[DEF]), .y(y_d[DEF]), .y_valid(yv_d[DEF]));

  typedef struct {
    int         dut;
    logic       rst;
    logic       en;
    logic [7:0] x;
    logic       ct;   // clk_transfer during the cycle
    logic [7:0] y;    // y after the edge ending the cycle
    logic       yv;
  } vec_t;

  vec_t vecs[$];
  int   h[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input int dut, input logic r, input logic e, input logic [7:0] xv,
                              input logic ct, input logic [7:0] yv8, input logic yv);
    vec_t v;
    v.dut = dut; v.rst = r; v.en = e; v.x = xv; v.ct = ct; v.y = yv8; v.yv = yv;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Impulse response of the default instance: (1 + z^-1 + ... + z^-(RM-1))^N.
  function automatic void build_h();
    int nh[$];
    h.delete();
    h.push_back(1);
    for (int s = 0; s < N_D; s++) begin
      nh.delete();
      for (int i = 0; i < h.size() + R_D * M_D - 1; i++) begin
        int a;
        a = 0;
        for (int j = 0; j < R_D * M_D; j++)
          if (i - j >= 0 && i - j < h.size()) a += h[i - j];
        nh.push_back(a);
      end
      h = nh;
    end
  endfunction

  // Alternating full-scale stream checked against y(t) = sum h[k] s(t-N-k) mod 2^W.
  task automatic wrap_run(input int nsamp, input string tag);
    int s_hist[$];
    for (int k = 0; k < nsamp * R_D; k++) begin
      logic [7:0]     xv;
      logic [W_D-1:0] a_w;
      int             acc;
      xv = ((k / R_D) % 2 == 0) ? 8'h7F : 8'h81;
      x_d[DEF] = xv;
      #1;
      chk($sformatf("%s_ct%0d", tag, k), 8'(ct_d[DEF]), 8'((k % R_D) == 0));
      s_hist.push_back((k % R_D == 0) ? int'($signed(xv)) : 0);
      @(posedge clk); #1;
      acc = 0;
      for (int j = 0; j < h.size(); j++) begin
        int idx;
        idx = k - N_D - j;
        if (idx >= 0) acc += h[j] * s_hist[idx];
      end
      a_w = W_D'(acc);
      chk($sformatf("%s_y%0d", tag, k), y_d[DEF], a_w[W_D-1 -: 8]);
      chk($sformatf("%s_yv%0d", tag, k), 8'(yv_d[DEF]), 8'd1);
    end
  endtask

  initial begin
    logic [7:0] ya [16];
    rst = 1'b1;
    en  = 1'b0;
    for (int j = 0; j < 4; j++) x_d[j] = 8'h00;

    // Reset held 3 cycles with enabled high
    for (int i = 0; i < 3; i++) add(DEF, 1, 1, 8'h00, 0, 8'h00, 0);

    // Zero-order hold: 20 for two samples, then -8, then 0; one cycle of pipe + one of y
    ya = '{8'h00, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14,
           8'h14, 8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'h00, 8'h00, 8'h00};
    for (int t = 0; t < 16; t++)
      add(ZOH, 0, 1, (t < 8) ? 8'h14 : (t < 12) ? 8'hF8 : 8'h00, (t % 4) == 0, ya[t], 1);

    // Linear interpolation 0 -> 16 with a 5-cycle enable gap mid-ramp
    add(RAMP, 1, 1, 8'h00, 0, 8'h00, 0);
    add(RAMP, 1, 1, 8'h00, 0, 8'h00, 0);
    add(RAMP, 0, 1, 8'h00, 1, 8'h00, 1);
    add(RAMP, 0, 1, 8'h00, 0, 8'h00, 1);
    add(RAMP, 0, 1, 8'h00, 0, 8'h00, 1);
    add(RAMP, 0, 1, 8'h00, 0, 8'h00, 1);
    add(RAMP, 0, 1, 8'h10, 1, 8'h00, 1);
    add(RAMP, 0, 1, 8'h10, 0, 8'h00, 1);
    add(RAMP, 0, 1, 8'h10, 0, 8'h04, 1);
    add(RAMP, 0, 1, 8'h10, 0, 8'h08, 1);
    for (int g = 0; g < 5; g++) add(RAMP, 0, 0, 8'hFF, 0, 8'h08, 0);
    add(RAMP, 0, 1, 8'h10, 1, 8'h0C, 1);
    add(RAMP, 0, 1, 8'h10, 0, 8'h10, 1);
    add(RAMP, 0, 1, 8'h10, 0, 8'h10, 1);
    add(RAMP, 0, 1, 8'h10, 0, 8'h10, 1);
    add(RAMP, 0, 1, 8'h10, 1, 8'h10, 1);
    add(RAMP, 0, 1, 8'h10, 0, 8'h10, 1);

    // Width rules: 3-bit precision, output left-justified into 8 bits
    add(WID, 1, 1, 8'h00, 0, 8'h00, 0);
    add(WID, 1, 1, 8'h00, 0, 8'h00, 0);
    add(WID, 0, 1, 8'h80, 1, 8'h00, 1);
    add(WID, 0, 1, 8'h80, 0, 8'h80, 1);
    add(WID, 0, 1, 8'h00, 1, 8'h80, 1);
    add(WID, 0, 1, 8'h00, 0, 8'h00, 1);
    add(WID, 0, 1, 8'h1F, 1, 8'h00, 1);
    add(WID, 0, 1, 8'h1F, 0, 8'h00, 1);
    add(WID, 0, 1, 8'h1F, 1, 8'h00, 1);
    add(WID, 0, 1, 8'h1F, 0, 8'h00, 1);
    add(WID, 0, 1, 8'h20, 1, 8'h00, 1);
    add(WID, 0, 1, 8'h00, 0, 8'h20, 1);
    add(WID, 0, 1, 8'h00, 1, 8'h20, 1);
    add(WID, 0, 1, 8'h00, 0, 8'h00, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v   = vecs[i];
      rst = v.rst;
      en  = v.en;
      for (int j = 0; j < 4; j++) x_d[j] = 8'h00;
      x_d[v.dut] = v.x;
      #1;
      chk($sformatf("v%0d_ct", i), 8'(ct_d[v.dut]), 8'(v.ct));
      @(posedge clk); #1;
      chk($sformatf("v%0d_y", i), y_d[v.dut], v.y);
      chk($sformatf("v%0d_yv", i), 8'(yv_d[v.dut]), 8'(v.yv));
    end

    // Full-scale wrap on the default instance, with a reset mid-stream
    build_h();
    rst = 1'b1;
    en  = 1'b1;
    for (int j = 0; j < 4; j++) x_d[j] = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    wrap_run(500, "wrapA");

    rst = 1'b1;
    x_d[DEF] = 8'h7F;
    #1;
    chk("midrst_ct", 8'(ct_d[DEF]), 8'd0);
    @(posedge clk); #1;
    chk("midrst_y", y_d[DEF], 8'h00);
    chk("midrst_yv", 8'(yv_d[DEF]), 8'd0);
    rst = 1'b0;
    wrap_run(500, "wrapB");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
